// File: rtl/park_pkg.sv
// Shared constants and helpers for the multi-lane parking occupancy controller.
package park_pkg;

    localparam int CAPACITY_DEF = 10;
    localparam int N_LANES_MIN  = 1;
    localparam int N_LANES_MAX  = 8;

    // Counts set bits of a lane vector zero-extended to the maximum lane count.
    function automatic logic [3:0] popcount(input logic [N_LANES_MAX-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < N_LANES_MAX; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/park_lane_grant.sv
// Combinational priority allocator: grants requesting lanes from index 0 upward
// until the available space is used up; remaining requesters are rejected.
module park_lane_grant #(
    parameter int N_LANES = 2,
    parameter int SPACE_W = 5
) (
    input  logic [N_LANES-1:0] req,
    input  logic [SPACE_W-1:0] space,
    output logic [N_LANES-1:0] grant,
    output logic [N_LANES-1:0] reject,
    output logic [SPACE_W-1:0] n_grant
);

    always_comb begin
        grant   = '0;
        reject  = '0;
        n_grant = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (req[i]) begin
                if (n_grant < space) begin
                    grant[i] = 1'b1;
                    n_grant  = n_grant + SPACE_W'(1);
                end else begin
                    reject[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/park_occupancy_ctrl.sv
// Lot occupancy tracker for N entry and N exit lanes with registered status flags,
// sticky exit-underflow error and a wrapping granted-entries statistic.
module park_occupancy_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY    = CAPACITY_DEF,
    parameter int N_LANES     = 2,
    parameter int CNT_W       = $clog2(CAPACITY + 1),
    parameter int ALMOST_FULL = CAPACITY - 2,
    parameter int STAT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] car_in,
    input  logic [N_LANES-1:0] car_out,
    input  logic               load_en,
    input  logic [CNT_W-1:0]   load_val,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   free,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic [N_LANES-1:0] in_grant,
    output logic [N_LANES-1:0] in_reject,
    output logic               out_err,
    output logic [STAT_W-1:0]  total_in
);

    // Wide enough for CAPACITY plus a full lane popcount without wrapping.
    localparam int SUM_W = (CNT_W + 1 > 4) ? CNT_W + 1 : 4;
    typedef logic [SUM_W-1:0] sum_t;

    sum_t               c_ext, n_out, a_out, space, a_in, load_sat, nxt_ext;
    logic               underflow;
    logic [N_LANES-1:0] req_eff, alloc_grant, alloc_reject;
    logic [N_LANES-1:0] nxt_grant, nxt_reject;
    logic [CNT_W-1:0]   nxt_cnt;

    always_comb begin
        c_ext     = sum_t'(count);
        n_out     = sum_t'(popcount(N_LANES_MAX'(car_out)));
        underflow = n_out > c_ext;
        a_out     = underflow ? c_ext : n_out;
        space     = sum_t'(CAPACITY) - c_ext + a_out;
        load_sat  = (sum_t'(load_val) > sum_t'(CAPACITY)) ? sum_t'(CAPACITY) : sum_t'(load_val);
        req_eff   = load_en ? '0 : car_in;
    end

    park_lane_grant #(
        .N_LANES(N_LANES),
        .SPACE_W(SUM_W)
    ) u_grant (
        .req    (req_eff),
        .space  (space),
        .grant  (alloc_grant),
        .reject (alloc_reject),
        .n_grant(a_in)
    );

    // A maintenance preset overrides every car event and refuses all requests.
    always_comb begin
        if (load_en) begin
            nxt_ext    = load_sat;
            nxt_grant  = '0;
            nxt_reject = car_in;
        end else begin
            nxt_ext    = c_ext - a_out + a_in;
            nxt_grant  = alloc_grant;
            nxt_reject = alloc_reject;
        end
        nxt_cnt = CNT_W'(nxt_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            free        <= CNT_W'(CAPACITY);
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= (ALMOST_FULL <= 0);
            in_grant    <= '0;
            in_reject   <= '0;
            out_err     <= 1'b0;
            total_in    <= '0;
        end else begin
            count       <= nxt_cnt;
            free        <= CNT_W'(CAPACITY) - nxt_cnt;
            full        <= (nxt_ext == sum_t'(CAPACITY));
            empty       <= (nxt_ext == '0);
            almost_full <= (int'(nxt_ext) >= ALMOST_FULL);
            in_grant    <= nxt_grant;
            in_reject   <= nxt_reject;
            if (!load_en) begin
                if (underflow) begin
                    out_err <= 1'b1;
                end
                total_in <= total_in + STAT_W'(a_in);
            end
        end
    end

endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// Directed vector bench for park_occupancy_ctrl (CAPACITY=10, 2 lanes, 4-bit statistic).
module tb_park_occupancy_ctrl;

    localparam int CAP = 10;
    localparam int NL  = 2;
    localparam int CW  = 4;
    localparam int SW  = 4;
    localparam int AF  = CAP - 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] car_in, car_out;
    logic          load_en;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count, free;
    logic          full, empty, almost_full, out_err;
    logic [NL-1:0] in_grant, in_reject;
    logic [SW-1:0] total_in;

    int checks = 0;
    int errors = 0;

    park_occupancy_ctrl #(
        .CAPACITY(CAP),
        .N_LANES (NL),
        .STAT_W  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .car_in     (car_in),
        .car_out    (car_out),
        .load_en    (load_en),
        .load_val   (load_val),
        .count      (count),
        .free       (free),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .in_grant   (in_grant),
        .in_reject  (in_reject),
        .out_err    (out_err),
        .total_in   (total_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ld;
        logic [CW-1:0] lv;
        logic [NL-1:0] ci;
        logic [NL-1:0] co;
        int            cnt;
        logic [NL-1:0] g;
        logic [NL-1:0] r;
        logic          err;
        int            tot;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input logic [NL-1:0] g,
                           input logic [NL-1:0] r, input logic err, input int tot);
        chk({tag, ".count"},       int'(count),       c);
        chk({tag, ".free"},        int'(free),        CAP - c);
        chk({tag, ".full"},        int'(full),        int'(c == CAP));
        chk({tag, ".empty"},       int'(empty),       int'(c == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(c >= AF));
        chk({tag, ".in_grant"},    int'(in_grant),    int'(g));
        chk({tag, ".in_reject"},   int'(in_reject),   int'(r));
        chk({tag, ".out_err"},     int'(out_err),     int'(err));
        chk({tag, ".total_in"},    int'(total_in),    tot);
    endtask

    task automatic drive(input logic ld, input logic [CW-1:0] lv,
                         input logic [NL-1:0] ci, input logic [NL-1:0] co);
        load_en  = ld;
        load_val = lv;
        car_in   = ci;
        car_out  = co;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           ld    lv  ci     co     cnt g      r      err   tot
        v[0]  = '{1'b0, 0,  2'b01, 2'b00, 1,  2'b01, 2'b00, 1'b0, 1};
        v[1]  = '{1'b0, 0,  2'b01, 2'b00, 2,  2'b01, 2'b00, 1'b0, 2};
        v[2]  = '{1'b0, 0,  2'b01, 2'b00, 3,  2'b01, 2'b00, 1'b0, 3};
        v[3]  = '{1'b0, 0,  2'b11, 2'b00, 5,  2'b11, 2'b00, 1'b0, 5};
        v[4]  = '{1'b1, 9,  2'b00, 2'b00, 9,  2'b00, 2'b00, 1'b0, 5};
        v[5]  = '{1'b0, 0,  2'b11, 2'b00, 10, 2'b01, 2'b10, 1'b0, 6};
        v[6]  = '{1'b0, 0,  2'b01, 2'b01, 10, 2'b01, 2'b00, 1'b0, 7};
        v[7]  = '{1'b0, 0,  2'b11, 2'b00, 10, 2'b00, 2'b11, 1'b0, 7};
        v[8]  = '{1'b0, 0,  2'b11, 2'b11, 10, 2'b11, 2'b00, 1'b0, 9};
        v[9]  = '{1'b1, 1,  2'b00, 2'b00, 1,  2'b00, 2'b00, 1'b0, 9};
        v[10] = '{1'b0, 0,  2'b00, 2'b11, 0,  2'b00, 2'b00, 1'b1, 9};
        v[11] = '{1'b0, 0,  2'b10, 2'b00, 1,  2'b10, 2'b00, 1'b1, 10};
        v[12] = '{1'b1, 15, 2'b11, 2'b11, 10, 2'b00, 2'b11, 1'b1, 10};
        v[13] = '{1'b0, 0,  2'b00, 2'b01, 9,  2'b00, 2'b00, 1'b1, 10};
        v[14] = '{1'b0, 0,  2'b00, 2'b11, 7,  2'b00, 2'b00, 1'b1, 10};
        v[15] = '{1'b1, 8,  2'b00, 2'b00, 8,  2'b00, 2'b00, 1'b1, 10};

        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        #12;
        chk_all("reset", 0, 2'b00, 2'b00, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(v[i].ld, v[i].lv, v[i].ci, v[i].co);
            step();
            chk_all($sformatf("vec%0d", i), v[i].cnt, v[i].g, v[i].r, v[i].err, v[i].tot);
        end

        // Asynchronous reset between edges with count=7 and requests pending.
        drive(1'b1, 7, 2'b00, 2'b00);
        step();
        chk("preload.count", int'(count), 7);
        drive(1'b0, '0, 2'b11, 2'b00);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 2'b00, 2'b00, 1'b0, 0);
        step();
        chk_all("rst_held", 0, 2'b00, 2'b00, 1'b0, 0);
        drive(1'b0, '0, 2'b00, 2'b00);
        rst = 1'b0;

        // Statistic wraps modulo 2^SW: 9 cycles of 2 grants from a reset total.
        drive(1'b1, 5, 2'b00, 2'b00);
        step();
        chk_all("wrap_load", 5, 2'b00, 2'b00, 1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, '0, 2'b11, 2'b11);
            step();
        end
        chk_all("wrap", 5, 2'b11, 2'b00, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/park_occupancy_ctrl.md
Name: park_occupancy_ctrl

Overview:
Multi-lane successor to the single-gate parking counter. It tracks lot occupancy against a parametrised capacity across N entry and N exit lanes. Per lane, it grants or rejects entry requests and flags exits that would underflow. It drives the full/empty/almost-full status used by the gate and display logic, and keeps a wrapping total-entries statistic.

Parameters:
CAPACITY, 10, maximum number of parked cars (≥1)
N_LANES, 2, number of entry lanes and number of exit lanes (1..8)
CNT_W, $clog2(CAPACITY+1), width of count/free
ALMOST_FULL, CAPACITY-2, almost_full asserts when count ≥ this value
STAT_W, 16, width of the total-entries statistic counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
car_in  in  N_LANES  per-lane entry request, one cycle per car
car_out  in  N_LANES  per-lane exit event, one cycle per car
load_en  in  1  synchronous occupancy preset (maintenance)
load_val  in  CNT_W  preset value
count  out  CNT_W  registered occupancy
free  out  CNT_W  registered CAPACITY-count
full  out  1  registered, count==CAPACITY
empty  out  1  registered, count==0
almost_full  out  1  registered, count≥ALMOST_FULL
in_grant  out  N_LANES  registered per-lane entry accepted (1-cycle pulse)
in_reject  out  N_LANES  registered per-lane entry refused (1-cycle pulse)
out_err  out  1  sticky, set by an exit with no car to remove
total_in  out  STAT_W  registered count of granted entries, wraps modulo 2^STAT_W

Behaviour:
- Reset (async, rst=1): count=0, free=CAPACITY, empty=1, full=0, almost_full=(ALMOST_FULL==0), in_grant=0, in_reject=0, out_err=0, total_in=0. Reset applied mid-cycle discards all pending events.
- All outputs are registered. Events sampled at edge k appear on outputs after edge k.
- Per cycle, with c = current count:
  - Exits: n_out = popcount(car_out); accepted exits a_out = min(n_out, c). If n_out > c, set out_err (sticky until rst). No exit is ever applied below 0.
  - Entries: space = CAPACITY - c + a_out. Exits in the same cycle free spots for entries in that cycle.
  - Grants go to requesting lanes in ascending index order (lane 0 highest priority), up to space. Remaining requesting lanes are rejected.
  - a_in = number granted. Next count = c - a_out + a_in, always in [0, CAPACITY].
- in_grant[i] / in_reject[i] are mutually exclusive. Both are 0 for a lane with no request.
- total_in += a_in, modulo 2^STAT_W.
- load_en=1 has priority over all car events that cycle:
  - count = min(load_val, CAPACITY); all requests that cycle are rejected; no out_err update; total_in unchanged.
- Flags (free, full, empty, almost_full) are derived from next count and registered in the same edge as count (no extra latency).
- Arithmetic: intermediate sums use CNT_W+1 bits to avoid wrap. No silent overflow is permitted.

Decomposition:
- Package park_pkg: CAPACITY default, lane-count limits, and a popcount function.
- Sub-module park_lane_grant: combinational priority allocator. Inputs are request vector and available space; outputs are grant/reject vectors and grant count. It is instantiated once for entries.
- Top module holds the count, flags, sticky error and statistic registers.

Test Plan:
1. Reset then 3 single-lane car_in pulses on lane 0 → count 1,2,3; in_grant[0] each cycle; total_in=3; empty=0.
2. CAPACITY=10, count=9, car_in=2'b11 → lane0 granted, lane1 rejected; count=10; full=1; almost_full=1.
3. count=10, car_in=2'b01 with car_out=2'b01 same cycle → grant lane0; count stays 10; no reject.
4. count=1, car_out=2'b11 → count=0; empty=1; out_err=1 and stays 1 after further valid traffic until rst.
5. load_en=1, load_val=15 (CAPACITY=10) with car_in=2'b11 → count=10; both lanes rejected; total_in unchanged.
6. Assert rst asynchronously between edges with count=7 → outputs return to reset values immediately, without waiting for a clock edge.
